// File: rtl/caxi4interconnect_open_trans_tracker.sv
// Per-master outstanding-transaction tracker: one slot per active AXI ID thread.
// Optional sticky protocol-error flag is built only when TRACKER_ERR_CHECK_EN is defined.
module caxi4interconnect_open_trans_tracker #(
    parameter int NUM_THREADS       = 2,
    parameter int NUM_THREADS_WIDTH = 1,
    parameter int MASTERID_WIDTH    = 4,
    parameter int NUM_SLAVES_WIDTH  = 2,
    parameter int OPEN_TRANS_MAX    = 3,
    parameter int OPEN_TRANS_WIDTH  = 2
) (
    input  logic                        sysClk,
    input  logic                        sysReset,
    input  logic [MASTERID_WIDTH-1:0]   currTransID,
    output logic                        threadAvail,
    output logic                        threadValid,
    output logic [OPEN_TRANS_WIDTH-1:0] threadCount,
    output logic [NUM_SLAVES_WIDTH-1:0] threadSlaveID,
    input  logic                        openTransInc,
    input  logic [MASTERID_WIDTH-1:0]   incTransID,
    input  logic [NUM_SLAVES_WIDTH-1:0] incSlaveID,
    input  logic                        openTransDec,
    input  logic [MASTERID_WIDTH-1:0]   decTransID,
    output logic                        trackErr
);

    localparam logic [OPEN_TRANS_WIDTH-1:0] MAX_CNT = OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX);
    localparam logic [OPEN_TRANS_WIDTH-1:0] ONE_CNT = OPEN_TRANS_WIDTH'(1);

    logic [NUM_THREADS-1:0]      r_open;
    logic [MASTERID_WIDTH-1:0]   r_id    [NUM_THREADS];
    logic [NUM_SLAVES_WIDTH-1:0] r_slave [NUM_THREADS];
    logic [OPEN_TRANS_WIDTH-1:0] r_count [NUM_THREADS];

    logic                         w_lookHit;
    logic [NUM_THREADS_WIDTH-1:0] w_lookIdx;
    logic                         w_incHit;
    logic [NUM_THREADS_WIDTH-1:0] w_incIdx;
    logic                         w_decHit;
    logic [NUM_THREADS_WIDTH-1:0] w_decIdx;
    logic                         w_freeAny;
    logic [NUM_THREADS_WIDTH-1:0] w_freeIdx;
    logic                         w_incOp;
    logic                         w_decOp;
    logic                         w_sameSlot;
    logic                         w_alloc;

    // Descending scans so the lowest matching/free index is the one left standing.
    always_comb begin
        w_lookHit = 1'b0;
        w_lookIdx = '0;
        w_incHit  = 1'b0;
        w_incIdx  = '0;
        w_decHit  = 1'b0;
        w_decIdx  = '0;
        w_freeAny = 1'b0;
        w_freeIdx = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (r_open[i] && (r_id[i] == currTransID)) begin
                w_lookHit = 1'b1;
                w_lookIdx = NUM_THREADS_WIDTH'(i);
            end
            if (r_open[i] && (r_id[i] == incTransID)) begin
                w_incHit = 1'b1;
                w_incIdx = NUM_THREADS_WIDTH'(i);
            end
            if (r_open[i] && (r_id[i] == decTransID)) begin
                w_decHit = 1'b1;
                w_decIdx = NUM_THREADS_WIDTH'(i);
            end
            if (!r_open[i]) begin
                w_freeAny = 1'b1;
                w_freeIdx = NUM_THREADS_WIDTH'(i);
            end
        end
    end

    assign w_incOp    = openTransInc && w_incHit;
    assign w_decOp    = openTransDec && w_decHit;
    assign w_sameSlot = w_incOp && w_decOp && (w_incIdx == w_decIdx);
    assign w_alloc    = openTransInc && !w_incHit && w_freeAny;

    assign threadAvail   = |(~r_open);
    assign threadValid   = w_lookHit;
    assign threadCount   = w_lookHit ? r_count[w_lookIdx] : '0;
    assign threadSlaveID = w_lookHit ? r_slave[w_lookIdx] : '0;

    // Allocation only ever targets a slot that was FREE before the edge, never one being freed now.
    always_ff @(posedge sysClk or negedge sysReset) begin
        if (!sysReset) begin
            r_open <= '0;
            for (int i = 0; i < NUM_THREADS; i++) begin
                r_id[i]    <= '0;
                r_slave[i] <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (w_sameSlot && (w_incIdx == NUM_THREADS_WIDTH'(i))) begin
                    r_count[i] <= r_count[i];
                end else if (w_incOp && (w_incIdx == NUM_THREADS_WIDTH'(i))) begin
                    if (r_count[i] != MAX_CNT) begin
                        r_count[i] <= r_count[i] + ONE_CNT;
                    end
                end else if (w_decOp && (w_decIdx == NUM_THREADS_WIDTH'(i))) begin
                    if (r_count[i] == ONE_CNT) begin
                        r_open[i]  <= 1'b0;
                        r_id[i]    <= '0;
                        r_slave[i] <= '0;
                        r_count[i] <= '0;
                    end else begin
                        r_count[i] <= r_count[i] - ONE_CNT;
                    end
                end else if (w_alloc && (w_freeIdx == NUM_THREADS_WIDTH'(i))) begin
                    r_open[i]  <= 1'b1;
                    r_id[i]    <= incTransID;
                    r_slave[i] <= incSlaveID;
                    r_count[i] <= ONE_CNT;
                end
            end
        end
    end

`ifdef TRACKER_ERR_CHECK_EN
    logic w_errNow;
    logic r_trackErr;

    // Dropped inc, unmatched dec, or saturating inc (a same-slot inc/dec pair is exempt).
    assign w_errNow = (openTransInc && !w_incHit && !w_freeAny)
                   || (openTransDec && !w_decHit)
                   || (w_incOp && !w_sameSlot && (r_count[w_incIdx] == MAX_CNT));

    always_ff @(posedge sysClk or negedge sysReset) begin
        if (!sysReset) begin
            r_trackErr <= 1'b0;
        end else if (w_errNow) begin
            r_trackErr <= 1'b1;
        end
    end

    assign trackErr = r_trackErr;
`else
    assign trackErr = 1'b0;
`endif

endmodule

// File: tb/tb_caxi4interconnect_open_trans_tracker.sv
// Self-checking bench for caxi4interconnect_open_trans_tracker: vector table, corner sequences, random vs model.
// Expected trackErr follows TRACKER_ERR_CHECK_EN as compiled.
module tb_caxi4interconnect_open_trans_tracker;

    localparam int NT      = 2;
    localparam int MAXC    = 3;
`ifdef TRACKER_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       sysClk;
    logic       sysReset;
    logic [3:0] currTransID;
    logic       threadAvail;
    logic       threadValid;
    logic [1:0] threadCount;
    logic [1:0] threadSlaveID;
    logic       openTransInc;
    logic [3:0] incTransID;
    logic [1:0] incSlaveID;
    logic       openTransDec;
    logic [3:0] decTransID;
    logic       trackErr;

    int checks = 0;
    int errors = 0;

    caxi4interconnect_open_trans_tracker dut (
        .sysClk        (sysClk),
        .sysReset      (sysReset),
        .currTransID   (currTransID),
        .threadAvail   (threadAvail),
        .threadValid   (threadValid),
        .threadCount   (threadCount),
        .threadSlaveID (threadSlaveID),
        .openTransInc  (openTransInc),
        .incTransID    (incTransID),
        .incSlaveID    (incSlaveID),
        .openTransDec  (openTransDec),
        .decTransID    (decTransID),
        .trackErr      (trackErr)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    // Reference model: open threads keyed by ID, with count and slave.
    int mdlCnt [int];
    int mdlSl  [int];
    bit mdlErr;

    task automatic modelStep(input bit inc, input int incId, input int incSl,
                             input bit dec, input int decId);
        bit incOpen;
        bit decOpen;
        bit newAlloc;
        int nOpen;
        incOpen  = mdlCnt.exists(incId);
        decOpen  = mdlCnt.exists(decId);
        nOpen    = mdlCnt.num();
        newAlloc = 1'b0;
        if (inc && dec && incOpen && decOpen && (incId == decId)) return;
        if (inc) begin
            if (incOpen) begin
                if (mdlCnt[incId] == MAXC) mdlErr = 1'b1;
                else mdlCnt[incId] = mdlCnt[incId] + 1;
            end else if (nOpen < NT) begin
                newAlloc = 1'b1;
            end else begin
                mdlErr = 1'b1;
            end
        end
        if (dec) begin
            if (decOpen) begin
                mdlCnt[decId] = mdlCnt[decId] - 1;
                if (mdlCnt[decId] == 0) begin
                    mdlCnt.delete(decId);
                    mdlSl.delete(decId);
                end
            end else begin
                mdlErr = 1'b1;
            end
        end
        if (newAlloc) begin
            mdlCnt[incId] = 1;
            mdlSl[incId]  = incSl;
        end
    endtask

    task automatic checkField(input string name, input string field, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s %s got %0d expected %0d", name, field, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int expValid, input int expCount,
                               input int expSlave, input int expAvail, input int expErr);
        checkField(name, "threadValid",   int'(threadValid),   expValid);
        checkField(name, "threadCount",   int'(threadCount),   expCount);
        checkField(name, "threadSlaveID", int'(threadSlaveID), expSlave);
        checkField(name, "threadAvail",   int'(threadAvail),   expAvail);
        checkField(name, "trackErr",      int'(trackErr),      expErr);
    endtask

    task automatic checkModel(input string name, input int look);
        int ev;
        int ec;
        int es;
        ev = mdlCnt.exists(look) ? 1 : 0;
        ec = ev ? mdlCnt[look] : 0;
        es = ev ? mdlSl[look] : 0;
        checkOutput(name, ev, ec, es, (mdlCnt.num() < NT) ? 1 : 0, (ERR_EN && mdlErr) ? 1 : 0);
    endtask

    // Drive one cycle of inc/dec, then present the lookup ID for the post-edge state.
    task automatic applyStimulus(input bit inc, input int incId, input int incSl,
                                 input bit dec, input int decId, input int look);
        openTransInc = inc;
        incTransID   = 4'(incId);
        incSlaveID   = 2'(incSl);
        openTransDec = dec;
        decTransID   = 4'(decId);
        @(posedge sysClk);
        modelStep(inc, incId, incSl, dec, decId);
        #1;
        openTransInc = 1'b0;
        openTransDec = 1'b0;
        currTransID  = 4'(look);
        #1;
    endtask

    task automatic doReset(input string name, input int look);
        openTransInc = 1'b0;
        openTransDec = 1'b0;
        currTransID  = 4'(look);
        sysReset     = 1'b0;
        #1;
        checkOutput(name, 0, 0, 0, 1, 0);
        mdlCnt.delete();
        mdlSl.delete();
        mdlErr = 1'b0;
        @(negedge sysClk);
        sysReset = 1'b1;
        @(posedge sysClk);
        #2;
    endtask

    typedef struct {
        int inc; int incId; int incSl; int dec; int decId; int look;
        int eValid; int eCount; int eSlave; int eAvail; int eErrFlag;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1, 5, 1, 0, 0, 5,  1, 1, 1, 1, 0};
        tbl[1]  = '{1, 5, 1, 0, 0, 5,  1, 2, 1, 1, 0};
        tbl[2]  = '{1, 5, 1, 0, 0, 5,  1, 3, 1, 1, 0};
        tbl[3]  = '{1, 5, 1, 0, 0, 5,  1, 3, 1, 1, 1};
        tbl[4]  = '{1, 2, 2, 0, 0, 2,  1, 1, 2, 0, 1};
        tbl[5]  = '{1, 9, 3, 0, 0, 9,  0, 0, 0, 0, 1};
        tbl[6]  = '{1, 5, 1, 1, 5, 5,  1, 3, 1, 0, 1};
        tbl[7]  = '{0, 0, 0, 1, 5, 5,  1, 2, 1, 0, 1};
        tbl[8]  = '{1, 4, 3, 1, 2, 2,  0, 0, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 4,  0, 0, 0, 1, 1};
        tbl[10] = '{1, 4, 3, 0, 0, 4,  1, 1, 3, 0, 1};
        tbl[11] = '{0, 0, 0, 1, 5, 5,  1, 1, 1, 0, 1};
        tbl[12] = '{0, 0, 0, 1, 5, 5,  0, 0, 0, 1, 1};
        tbl[13] = '{1, 7, 2, 0, 0, 7,  1, 1, 2, 0, 1};

        sysReset     = 1'b0;
        currTransID  = 4'd5;
        openTransInc = 1'b0;
        incTransID   = '0;
        incSlaveID   = '0;
        openTransDec = 1'b0;
        decTransID   = '0;
        mdlErr       = 1'b0;
        #3;
        checkOutput("resetInit", 0, 0, 0, 1, 0);
        #4;
        sysReset = 1'b1;
        @(posedge sysClk);
        #2;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].inc[0], tbl[i].incId, tbl[i].incSl,
                          tbl[i].dec[0], tbl[i].decId, tbl[i].look);
            checkOutput($sformatf("vec%0d", i), tbl[i].eValid, tbl[i].eCount, tbl[i].eSlave,
                        tbl[i].eAvail, (ERR_EN && tbl[i].eErrFlag != 0) ? 1 : 0);
        end

        doReset("midReset", 4);

        applyStimulus(1'b0, 0, 0, 1'b1, 3, 3);
        checkOutput("decNoMatch", 0, 0, 0, 1, ERR_EN ? 1 : 0);

        doReset("reset2", 2);
        applyStimulus(1'b1, 2, 1, 1'b0, 0, 2);
        checkOutput("fill2", 1, 1, 1, 1, 0);
        applyStimulus(1'b1, 7, 3, 1'b0, 0, 7);
        checkOutput("fill7", 1, 1, 3, 0, 0);
        applyStimulus(1'b1, 9, 2, 1'b0, 0, 9);
        checkOutput("dropInc9", 0, 0, 0, 0, ERR_EN ? 1 : 0);

        doReset("reset3", 0);
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 99) begin
                doReset("randReset", int'($urandom_range(4)));
            end else begin
                applyStimulus(($urandom_range(99) < 55), int'($urandom_range(4)), int'($urandom_range(3)),
                              ($urandom_range(99) < 45), int'($urandom_range(4)), int'($urandom_range(4)));
                checkModel($sformatf("rand%0d", n), int'(currTransID));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/caxi4interconnect_open_trans_tracker.md
Name: caxi4interconnect_open_trans_tracker

Overview:
Per-master-port controller that tracks outstanding AXI transactions per ID thread. It supplies threadAvail, threadValid, threadCount and threadSlaveID to the dependence checker for the current request. It updates its thread table when an address handshake completes and when a final response beat returns. One instance sits in each master's read path and one in each master's write path inside the crossbar.

Parameters:
NUM_THREADS, 2, number of independent ID threads tracked per master port (1..8).
NUM_THREADS_WIDTH, 1, bits to encode a thread slot index.
MASTERID_WIDTH, 4, width of transaction ID (infrastructure ID + requestor ID).
NUM_SLAVES_WIDTH, 2, width of slave ID (derrSlave included).
OPEN_TRANS_MAX, 3, maximum outstanding transactions per thread.
OPEN_TRANS_WIDTH, 2, width of per-thread count; must hold OPEN_TRANS_MAX.

Ports:
sysClk  input  1  clock; all state updates on rising edge.
sysReset  input  1  asynchronous, active-low reset.
currTransID  input  MASTERID_WIDTH  ID of the request being qualified (lookup key).
threadAvail  output  1  at least one slot is FREE.
threadValid  output  1  an OPEN slot holds currTransID.
threadCount  output  OPEN_TRANS_WIDTH  outstanding count of the matched slot; 0 if no match.
threadSlaveID  output  NUM_SLAVES_WIDTH  slave ID of the matched slot; 0 if no match.
openTransInc  input  1  address handshake accepted this cycle.
incTransID  input  MASTERID_WIDTH  ID of the accepted request.
incSlaveID  input  NUM_SLAVES_WIDTH  target slave of the accepted request.
openTransDec  input  1  final response beat accepted this cycle (RLAST or B).
decTransID  input  MASTERID_WIDTH  ID of the completed transaction.
trackErr  output  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Per slot state: FREE or OPEN, plus registered id, slaveID and count.
- Reset (sysReset low, async): all slots FREE; id, slaveID and count = 0; trackErr = 0. Outputs while in reset: threadAvail = 1, threadValid = 0, threadCount = 0, threadSlaveID = 0.
- Lookup is combinational from registered state. It has no bypass of same-cycle inc/dec; an update becomes visible the cycle after the edge.
- Multiple OPEN slots must never share an ID. If they do by construction error, the lowest index wins.
- Inc, ID matches an OPEN slot: count += 1 and slaveID is unchanged. The checker guarantees the same target.
- Inc, no match, FREE slot exists: the lowest-index FREE slot (based on start-of-cycle state) goes FREE->OPEN with id = incTransID, slaveID = incSlaveID, count = 1.
- Inc, no match, no FREE slot: ignored and error raised.
- Inc on a slot at count == OPEN_TRANS_MAX: count saturates and error is raised.
- Dec, ID matches an OPEN slot: count -= 1. If the count reaches 0, the slot goes OPEN->FREE and id/slaveID clear to 0.
- Dec with no matching OPEN slot: ignored and error raised.
- Inc and dec in the same cycle on the same OPEN slot: count unchanged, slot stays OPEN, no error (even at OPEN_TRANS_MAX).
- Inc allocating a new slot while a dec frees a different slot in the same cycle:
  - Allocation uses the pre-edge FREE vector, so the slot being freed is not reusable this cycle.
  - If no other slot is free, the inc is dropped and an error is raised.
- Inc and dec for different OPEN slots in the same cycle are handled independently.
- Count arithmetic is unsigned, OPEN_TRANS_WIDTH bits, and never wraps: inc saturates, and dec at 0 cannot occur on an OPEN slot.

Optional Feature:
TRACKER_ERR_CHECK_EN.
- Defined: the error conditions above set trackErr on the following edge. trackErr stays 1 until reset.
- Undefined: error detection logic is removed and trackErr is tied 0. Inc/dec behaviour, including saturation and ignored operations, is identical.

Test Plan:
- Reset, then inc ID=5 to slave 1 -> next cycle lookup ID=5: threadValid=1, threadCount=1, threadSlaveID=1, threadAvail=1.
- Three more incs ID=5 (4 total, OPEN_TRANS_MAX=3) -> threadCount=3 after the 3rd; trackErr=1 after the 4th (macro on), 0 with macro off.
- Inc ID=2, inc ID=7 (NUM_THREADS=2) -> threadAvail=0. Inc ID=9 -> dropped, lookup ID=9 threadValid=0, trackErr=1.
- With ID=5 at count 1, same-cycle dec ID=5 and inc ID=5 -> count stays 1, slot OPEN. Then a lone dec -> threadValid=0, threadAvail=1.
- Dec ID=3 with no open thread -> no state change, trackErr=1. Assert sysReset mid-operation with 2 slots open -> immediately threadValid=0, threadAvail=1, trackErr=0.
- Both slots OPEN (ID=2 count 1, ID=7); same cycle dec ID=2 and inc new ID=4 -> inc dropped, slot 0 FREE. The following cycle, inc ID=4 allocates slot 0 with count=1.
